inst_fetch: RTL
===============

# inst_fetch

Instruction-fetch stage of the five-stage pipeline: owns the program counter and drives the read side of the instruction memory (address + chip enable), capturing the returned word into the IF/ID pipeline register. It accepts stall requests from the hazard unit and branch redirects resolved in ID. It also keeps a count of instructions delivered to ID.

## Interface

- `RESET_PC`, 32'h0000_0000, PC value loaded by reset and fetched first
- `clk`  in  1  pipeline clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall_i`  in  1  hold PC and IF/ID contents this cycle
- `branch_flag_i`  in  1  taken branch/jump resolved in ID this cycle
- `branch_target_i`  in  32  redirect address, valid with `branch_flag_i`
- `rom_data_i`  in  32  instruction word from memory (combinational on `rom_addr_o`)
- `rom_addr_o`  out  32  fetch address (= PC)
- `rom_ce_o`  out  1  memory chip enable (`CHIP_ENABLE`/`CHIP_DISABLE`)
- `id_pc_o`  out  32  PC of instruction held in IF/ID
- `id_inst_o`  out  32  instruction held in IF/ID
- `id_valid_o`  out  1  IF/ID holds a real instruction (0 = bubble)
- `fetch_cnt_o`  out  32  instructions delivered to ID since reset

## Operation

- State: `OFF` (`rom_ce_o`=0) and `RUN` (`rom_ce_o`=1). Reset forces `OFF`. First rising edge with `rst_n`=1 moves to `RUN`. `RUN` is held until the next reset.
- In `OFF`:
  - PC holds `RESET_PC`.
  - IF/ID holds a bubble.
  - `rom_data_i` is ignored. The memory returns `ZERO_WORD` in this state anyway.
- In `RUN`, priority per edge is branch > stall > normal:
  - Branch (`branch_flag_i`=1):
    - PC <= {`branch_target_i`[31:2], 2'b00}.
    - IF/ID <= bubble. The instruction currently in IF is squashed; there is no delay slot.
    - Applies even if `stall_i`=1.
  - Stall (`stall_i`=1, no branch): PC, IF/ID and `fetch_cnt_o` all hold.
  - Normal:
    - IF/ID <= {PC, `rom_data_i`, valid=1}.
    - PC <= PC + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Bubble encoding: `id_inst_o`=`ZERO_WORD`, `id_pc_o`=32'h0, `id_valid_o`=0.
- `fetch_cnt_o`:
  - Increments, wrapping modulo 2^32, on every edge where IF/ID loads a valid instruction (the normal case only).
  - Does not count bubbles or stalled cycles.
- `rom_addr_o` = PC at all times, including in `OFF`.
- `rom_ce_o` is a register output, not decoded from PC.

## Timing

- Reset values:
  - `rom_ce_o`=0, `rom_addr_o`=`RESET_PC`.
  - `id_pc_o`=0, `id_inst_o`=0, `id_valid_o`=0.
  - `fetch_cnt_o`=0.
- Asserting `rst_n` low mid-run clears all state immediately, without waiting for a clock edge. PC returns to `RESET_PC` and any in-flight IF/ID instruction is dropped.
- Latency after reset release:
  - Edge 1: `OFF` -> `RUN`.
  - Edge 2: word at `RESET_PC` appears on `id_inst_o`, and `rom_addr_o` = `RESET_PC`+4.
- Throughput: one instruction per cycle when neither stall nor branch is active.
- Branch penalty:
  - Edge E with `branch_flag_i`=1: bubble in ID, `rom_addr_o` = target.
  - Edge E+1: target instruction appears in ID.
- `stall_i` and `branch_flag_i` are sampled only on rising edges. Combinational changes between edges have no effect except on `rom_addr_o`-driven memory output.
- Any `branch_flag_i` seen while in `OFF` is ignored.

## Test plan

- Reset release with the standard ROM image:
  - Edge 1 -> `rom_ce_o`=1, `rom_addr_o`=0.
  - Edge 2 -> `id_inst_o`=34018000, `id_pc_o`=0, `rom_addr_o`=4, `fetch_cnt_o`=1.
  - Edge 3 -> `id_inst_o`=00010c00, `id_pc_o`=4.
- Stall: run to `id_pc_o`=8, then hold `stall_i`=1 for 3 edges.
  - Required: `id_inst_o`=34210010, `rom_addr_o`=C, and `fetch_cnt_o` unchanged throughout.
  - Release -> `id_pc_o`=C.
- Branch with stall: `branch_flag_i`=1, target 32'h0000_0047, `stall_i`=1 in the same cycle.
  - Next edge -> `rom_addr_o`=44, `id_valid_o`=0, counter unchanged.
  - Following edge -> `id_inst_o`=0020102a, `id_pc_o`=44.
- Wrap-around: `RESET_PC`=32'hFFFF_FFFC -> after first valid capture, `id_pc_o`=FFFF_FFFC and `rom_addr_o`=0.
- Mid-run reset: drop `rst_n` between edges while `id_valid_o`=1.
  - Required immediately: `rom_ce_o`=0, `id_valid_o`=0, `fetch_cnt_o`=0, `rom_addr_o`=`RESET_PC`.
  - The normal fetch sequence resumes after release.
- Fetch past the end of the program (address 54) -> `id_inst_o`=`ZERO_WORD` with `id_valid_o`=1, counted.

Source files
------------

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction-fetch stage. Owns the PC, drives the instruction
//            memory read port and loads the IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] rom_data_i,
    output logic [31:0] rom_addr_o,
    output logic        rom_ce_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic [31:0] fetch_cnt_o
);

    localparam logic [31:0] c_zero_word    = 32'h0000_0000;
    localparam logic        c_chip_enable  = 1'b1;
    localparam logic        c_chip_disable = 1'b0;

    typedef enum logic [0:0] {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_ce;
    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic [31:0] r_fetch_cnt;

    // Branch targets are forced word-aligned, so the low bits are dropped.
    logic [1:0]  w_unused_tgt_lsb;
    assign w_unused_tgt_lsb = branch_target_i[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_OFF;
            r_ce        <= c_chip_disable;
            r_pc        <= RESET_PC;
            r_id_pc     <= 32'h0;
            r_id_inst   <= c_zero_word;
            r_id_valid  <= 1'b0;
            r_fetch_cnt <= 32'h0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_state    <= ST_RUN;
                    r_ce       <= c_chip_enable;
                    r_pc       <= RESET_PC;
                    r_id_pc    <= 32'h0;
                    r_id_inst  <= c_zero_word;
                    r_id_valid <= 1'b0;
                end
                ST_RUN: begin
                    // Branch wins over stall: the instruction in IF is squashed.
                    if (branch_flag_i) begin
                        r_pc       <= {branch_target_i[31:2], 2'b00};
                        r_id_pc    <= 32'h0;
                        r_id_inst  <= c_zero_word;
                        r_id_valid <= 1'b0;
                    end else if (!stall_i) begin
                        r_pc        <= r_pc + 32'd4;
                        r_id_pc     <= r_pc;
                        r_id_inst   <= rom_data_i;
                        r_id_valid  <= 1'b1;
                        r_fetch_cnt <= r_fetch_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_ce    <= c_chip_disable;
                end
            endcase
        end
    end

    assign rom_addr_o  = r_pc;
    assign rom_ce_o    = r_ce;
    assign id_pc_o     = r_id_pc;
    assign id_inst_o   = r_id_inst;
    assign id_valid_o  = r_id_valid;
    assign fetch_cnt_o = r_fetch_cnt;

endmodule
`default_nettype wire
